// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank: SPI mode-0 slave with a 2**ADDR_W x 8 register bank.
// SPI pins are oversampled in the HCLK domain (2-flop sync, edge detect on
// the synchronised SCLK). Frame: command byte (0x0A write / 0x0B read),
// address byte, then data bytes with an auto-incrementing, wrapping address.
// reg 0 = DEVICE_ID (read-only), reg 1 = last sample_in (read-only).
//
// Optional feature macro: SPI_SLV_ERR_FLAG_EN
//   defined   : top register is a read-only sticky error register
//               (bit0 illegal command, bit1 CS rose mid-byte,
//               bit2 write to read-only address), cleared when loaded for read.
//   undefined : top register is an ordinary R/W register.
//
// Ports:
//   HCLK, HRESETn     system clock, synchronous active-low reset
//   SCLK, CS, MOSI    SPI inputs from the master (CS active-low)
//   MISO              SPI data out, MSB first
//   sample_in/_valid  local sample captured into reg 1
//   wr_pulse/addr/data 1-cycle strobe with address/data of each SPI write
//   busy              1 while synchronised CS is low
module spi_slave_regbank #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  DEVICE_ID = 8'hAD
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        CMD_WR   = 8'h0A;
    localparam logic [7:0]        CMD_RD   = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WR,
        S_RD,
        S_IGN
    } state_t;

    // Synchronisers
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       cs_s1_q, cs_s2_q, cs_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] sync_vld_q;

    // Datapath / control state
    state_t            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic [7:0]        regs_q [DEPTH];

    logic              sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;
    logic [7:0]        rx_full_c;
    logic              byte_done_c;
    logic              ld_c, wr_en_c, wr_ok_c;
    logic [ADDR_W-1:0] ld_addr_c;
    logic [7:0]        rd_val_c;

`ifdef SPI_SLV_ERR_FLAG_EN
    logic [2:0] err_q, err_d, err_set_c;
`endif

    // CS flops reset low so that a CS already low at reset release is not
    // seen as a fall: a genuine high must be sampled first.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            cs_s1_q    <= 1'b0;
            cs_s2_q    <= 1'b0;
            cs_s3_q    <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            sync_vld_q <= 2'b00;
        end else begin
            sclk_s1_q  <= SCLK;
            sclk_s2_q  <= sclk_s1_q;
            sclk_s3_q  <= sclk_s2_q;
            cs_s1_q    <= CS;
            cs_s2_q    <= cs_s1_q;
            cs_s3_q    <= cs_s2_q;
            mosi_s1_q  <= MOSI;
            mosi_s2_q  <= mosi_s1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    assign sclk_rise_c = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall_c = ~sclk_s2_q & sclk_s3_q;
    assign cs_fall_c   = cs_s3_q & ~cs_s2_q;
    assign cs_rise_c   = cs_s2_q & ~cs_s3_q;
    assign rx_full_c   = {rx_q[6:0], mosi_s2_q};
    assign byte_done_c = sclk_rise_c & ~cs_s2_q & (bitcnt_q == 3'd7);

`ifdef SPI_SLV_ERR_FLAG_EN
    assign wr_ok_c = (addr_q >= ADDR_W'(2)) && (addr_q != TOP_ADDR);
`else
    assign wr_ok_c = (addr_q >= ADDR_W'(2));
`endif

    // Read mux: address byte loads from the just-received address
    always_comb begin
        ld_addr_c = (state_q == S_ADDR) ? rx_full_c[ADDR_W-1:0] : addr_q;
        rd_val_c  = regs_q[ld_addr_c];
        if (ld_addr_c == '0) begin
            rd_val_c = DEVICE_ID;
        end
`ifdef SPI_SLV_ERR_FLAG_EN
        if (ld_addr_c == TOP_ADDR) begin
            rd_val_c = {5'b0, err_q};
        end
`endif
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = sync_vld_q[1] & ~cs_s2_q;
        ld_c       = 1'b0;
        wr_en_c    = 1'b0;
`ifdef SPI_SLV_ERR_FLAG_EN
        err_set_c  = 3'b000;
`endif

        if (cs_s2_q) begin
            state_d  = S_IDLE;
            bitcnt_d = 3'd0;
            tx_d     = 8'h00;
`ifdef SPI_SLV_ERR_FLAG_EN
            if (cs_rise_c && (bitcnt_q != 3'd0)) begin
                err_set_c[1] = 1'b1;
            end
`endif
        end else begin
            if (sclk_rise_c) begin
                rx_d     = rx_full_c;
                bitcnt_d = bitcnt_q + 3'd1;
            end
            // No shift on the fall right after a byte completes: the freshly
            // loaded MSB must be presented for the first rise of the next byte.
            if (sclk_fall_c && (bitcnt_q != 3'd0)) begin
                tx_d = {tx_q[6:0], 1'b0};
            end

            case (state_q)
                S_IDLE: begin
                    if (cs_fall_c) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (byte_done_c) begin
                        if (rx_full_c == CMD_WR) begin
                            rd_d    = 1'b0;
                            state_d = S_ADDR;
                        end else if (rx_full_c == CMD_RD) begin
                            rd_d    = 1'b1;
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_IGN;
`ifdef SPI_SLV_ERR_FLAG_EN
                            err_set_c[0] = 1'b1;
`endif
                        end
                    end
                end
                S_ADDR: begin
                    if (byte_done_c) begin
                        if (rd_q) begin
                            state_d = S_RD;
                            ld_c    = 1'b1;
                            addr_d  = rx_full_c[ADDR_W-1:0] + ADDR_W'(1);
                        end else begin
                            state_d = S_WR;
                            addr_d  = rx_full_c[ADDR_W-1:0];
                        end
                    end
                end
                S_WR: begin
                    if (byte_done_c) begin
                        if (wr_ok_c) begin
                            wr_en_c    = 1'b1;
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = rx_full_c;
                        end
`ifdef SPI_SLV_ERR_FLAG_EN
                        else begin
                            err_set_c[2] = 1'b1;
                        end
`endif
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                S_RD: begin
                    if (byte_done_c) begin
                        ld_c   = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                S_IGN: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (ld_c) begin
                tx_d = rd_val_c;
            end
        end
    end

`ifdef SPI_SLV_ERR_FLAG_EN
    // Clear-on-load, but an error flagged in the same cycle survives
    always_comb begin
        err_d = err_q;
        if (ld_c && (ld_addr_c == TOP_ADDR)) begin
            err_d = 3'b000;
        end
        err_d = err_d | err_set_c;
    end
`endif

    // State and register bank
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
`ifdef SPI_SLV_ERR_FLAG_EN
            err_q      <= 3'b000;
`endif
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            if (wr_en_c) begin
                regs_q[addr_q] <= rx_full_c;
            end
            if (sample_valid) begin
                regs_q[1] <= sample_in;
            end
`ifdef SPI_SLV_ERR_FLAG_EN
            err_q      <= err_d;
`endif
        end
    end

    assign MISO     = tx_q[7];
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: drives SPI frames byte-by-byte, predicts MISO
// bytes and write strobes from a byte-level model of the register bank.
module tb_spi_slave_regbank;

    localparam int unsigned H = 5;  // SCLK half period in HCLK cycles

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       SCLK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] sample_in = 8'h00;
    logic       sample_valid = 1'b0;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    spi_slave_regbank #(.ADDR_W(4), .DEVICE_ID(8'hAD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .sample_in(sample_in), .sample_valid(sample_valid),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] m_mem [16];
    logic [7:0] m_err;
    wr_t        exp_wr [$];

    logic [7:0] f_tx  [$];
    logic [7:0] f_exp [$];
    logic [7:0] f_rx  [$];
    int         f_abort;
    int         f_sidx;
    logic [7:0] f_sval;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_err = 8'h00;
        exp_wr.delete();
    endtask

    task automatic m_read(input logic [3:0] a, output logic [7:0] v);
        if (a == 4'h0) v = 8'hAD;
`ifdef SPI_SLV_ERR_FLAG_EN
        else if (a == 4'hF) begin
            v = m_err;
            m_err = 8'h00;
        end
`endif
        else v = m_mem[a];
    endtask

    task automatic m_write(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
`ifdef SPI_SLV_ERR_FLAG_EN
        if (a >= 4'h2 && a != 4'hF) begin
`else
        if (a >= 4'h2) begin
`endif
            m_mem[a] = d;
            e.a = a;
            e.d = d;
            exp_wr.push_back(e);
        end
`ifdef SPI_SLV_ERR_FLAG_EN
        else m_err = m_err | 8'h04;
`endif
    endtask

    // Walks the frame byte by byte; each completed read-side byte loads the
    // value that appears on MISO during the following byte.
    task automatic model_frame();
        int         n = f_tx.size();
        int         mode = 0;  // 1 write, 2 read, 3 ignore
        logic [3:0] a = 4'h0;
        logic [7:0] v;
        f_exp.delete();
        for (int i = 0; i < n; i++) f_exp.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                mode = (f_tx[0] == 8'h0A) ? 1 : (f_tx[0] == 8'h0B) ? 2 : 3;
`ifdef SPI_SLV_ERR_FLAG_EN
                if (mode == 3) m_err = m_err | 8'h01;
`endif
            end else if (mode == 1) begin
                if (i == 1) a = f_tx[1][3:0];
                else begin
                    m_write(a, f_tx[i]);
                    a = a + 4'h1;
                end
            end else if (mode == 2) begin
                if (i == 1) a = f_tx[1][3:0];
                m_read(a, v);
                a = a + 4'h1;
                if (i + 1 < n) f_exp[i+1] = v;
            end
            if (i == f_sidx) m_mem[1] = f_sval;
        end
`ifdef SPI_SLV_ERR_FLAG_EN
        if (f_abort > 0) m_err = m_err | 8'h02;
`endif
    endtask

    // ---------------- SPI master ----------------
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit strobe,
                            input logic [7:0] sval, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            repeat (H) @(negedge HCLK);
            SCLK = 1'b1;
            r = {r[6:0], MISO};
            if (strobe && i == 7) begin
                // land sample_valid on the same HCLK edge as the byte-end load
                repeat (2) @(negedge HCLK);
                sample_in = sval;
                sample_valid = 1'b1;
                @(negedge HCLK);
                sample_valid = 1'b0;
                repeat (H - 3) @(negedge HCLK);
            end else begin
                repeat (H) @(negedge HCLK);
            end
            SCLK = 1'b0;
        end
    endtask

    task automatic f_new(input int abort, input int sidx, input logic [7:0] sval);
        f_tx.delete();
        f_abort = abort;
        f_sidx = sidx;
        f_sval = sval;
    endtask

    task automatic run_frame();
        logic [7:0] r;
        model_frame();
        @(negedge HCLK);
        chk("miso_idle", 32'(MISO), 32'd0);
        CS = 1'b0;
        repeat (H) @(negedge HCLK);
        chk("busy_low_cs", 32'(busy), 32'd1);
        f_rx.delete();
        for (int i = 0; i < f_tx.size(); i++) begin
            spi_bits(f_tx[i], 8, (i == f_sidx), f_sval, r);
            f_rx.push_back(r);
        end
        if (f_abort > 0) spi_bits(8'($urandom), f_abort, 1'b0, 8'h00, r);
        repeat (H) @(negedge HCLK);
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (3 * H) @(negedge HCLK);
        chk("busy_high_cs", 32'(busy), 32'd0);
        for (int i = 0; i < f_tx.size(); i++) chk($sformatf("miso_byte%0d", i), 32'(f_rx[i]), 32'(f_exp[i]));
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic pulse_sample(input logic [7:0] v);
        @(negedge HCLK);
        sample_in = v;
        sample_valid = 1'b1;
        @(negedge HCLK);
        sample_valid = 1'b0;
        m_mem[1] = v;
    endtask

    // ---------------- per-cycle write-strobe checker ----------------
    logic prev_pulse = 1'b0;
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (wr_pulse) begin
                chk("wr_pulse_single", 32'(prev_pulse), 32'd0);
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_pulse_unexpected: got pulse addr %0h data %0h, expected no pulse", wr_addr, wr_data);
                end else begin
                    chk("wr_addr", 32'(wr_addr), 32'(exp_wr[0].a));
                    chk("wr_data", 32'(wr_data), 32'(exp_wr[0].d));
                    void'(exp_wr.pop_front());
                end
            end
            prev_pulse <= wr_pulse;
        end else begin
            prev_pulse <= 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] r;
        int         kind, n;
        logic [7:0] c;

        m_reset();
        repeat (3) @(negedge HCLK);
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);

        // Read ID
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h00); f_tx.push_back(8'h00);
        run_frame();
        chk("t1_id", 32'(f_rx[2]), 32'hAD);

        // Burst write with wrap
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0A); f_tx.push_back(8'h0E); f_tx.push_back(8'h11);
        f_tx.push_back(8'h22); f_tx.push_back(8'h33);
        model_frame();
`ifdef SPI_SLV_ERR_FLAG_EN
        chk("t2_nwr", 32'(exp_wr.size()), 32'd1);
        chk("t2_err", 32'(m_err), 32'h04);
`else
        chk("t2_nwr", 32'(exp_wr.size()), 32'd2);
        chk("t2_w1", 32'(exp_wr[1]), 32'h0F22);
`endif
        chk("t2_w0", 32'(exp_wr[0]), 32'h0E11);
        // model already applied; replay it on the pins against a fresh copy
        m_reset();
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0A); f_tx.push_back(8'h0E); f_tx.push_back(8'h11);
        f_tx.push_back(8'h22); f_tx.push_back(8'h33);
        run_frame();

        // Burst read across the wrap
        pulse_sample(8'h3C);
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h0F);
        f_tx.push_back(8'h00); f_tx.push_back(8'h00); f_tx.push_back(8'h00);
        run_frame();
`ifdef SPI_SLV_ERR_FLAG_EN
        chk("t3_top", 32'(f_rx[2]), 32'h04);
`else
        chk("t3_top", 32'(f_rx[2]), 32'h22);
`endif
        chk("t3_id", 32'(f_rx[3]), 32'hAD);
        chk("t3_sample", 32'(f_rx[4]), 32'h3C);

        // Sample capture, then strobe coinciding with the load
        pulse_sample(8'h5C);
        f_new(0, 1, 8'hA7);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h01); f_tx.push_back(8'h00);
        run_frame();
        chk("t4_old_sample", 32'(f_rx[2]), 32'h5C);
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h01); f_tx.push_back(8'h00);
        run_frame();
        chk("t4_new_sample", 32'(f_rx[2]), 32'hA7);

        // Abort mid write byte
        f_new(4, -1, 8'h00);
        f_tx.push_back(8'h0A); f_tx.push_back(8'h06);
        run_frame();
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h06); f_tx.push_back(8'h00);
        run_frame();
        chk("t5_no_write", 32'(f_rx[2]), 32'h00);
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h0F); f_tx.push_back(8'h00);
        run_frame();
`ifdef SPI_SLV_ERR_FLAG_EN
        chk("t5_err", 32'(f_rx[2]), 32'h02);
`else
        chk("t5_top", 32'(f_rx[2]), 32'h22);
`endif

        // Randomised frames
        repeat (40) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                pulse_sample(8'($urandom));
            end else begin
                f_new(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, -1, 8'h00);
                n = $urandom_range(1, 4);
                if (kind == 0) begin
                    f_tx.push_back(8'h0A);
                    f_tx.push_back(8'($urandom));
                    for (int i = 0; i < n; i++) f_tx.push_back(8'($urandom));
                end else if (kind == 1) begin
                    f_tx.push_back(8'h0B);
                    f_tx.push_back(8'($urandom));
                    for (int i = 0; i < n; i++) f_tx.push_back(8'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        f_sidx = $urandom_range(1, n + 1);
                        f_sval = 8'($urandom);
                    end
                end else begin
                    c = 8'($urandom);
                    if (c == 8'h0A || c == 8'h0B) c = c ^ 8'h80;
                    f_tx.push_back(c);
                    for (int i = 0; i < n - 1; i++) f_tx.push_back(8'($urandom));
                end
                run_frame();
            end
        end

        // Mid-frame reset with CS held low
        @(negedge HCLK);
        CS = 1'b0;
        repeat (H) @(negedge HCLK);
        spi_bits(8'h0B, 8, 1'b0, 8'h00, r);
        spi_bits(8'h00, 8, 1'b0, 8'h00, r);
        repeat (4) @(negedge HCLK);
        chk("t6_pre_miso", 32'(MISO), 32'd1);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        chk("t6_rst_miso", 32'(MISO), 32'd0);
        chk("t6_rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_rst_wr_data", 32'(wr_data), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        m_reset();
        spi_bits(8'h0A, 8, 1'b0, 8'h00, r);
        spi_bits(8'h05, 8, 1'b0, 8'h00, r);
        spi_bits(8'h77, 8, 1'b0, 8'h00, r);
        chk("t6_busy_after_rst", 32'(busy), 32'd1);
        chk("t6_miso_ignored", 32'(MISO), 32'd0);
        repeat (H) @(negedge HCLK);
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (3 * H) @(negedge HCLK);
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h05); f_tx.push_back(8'h00);
        run_frame();
        chk("t6_no_write", 32'(f_rx[2]), 32'h00);
        f_new(0, -1, 8'h00);
        f_tx.push_back(8'h0B); f_tx.push_back(8'h00);
        f_tx.push_back(8'h00); f_tx.push_back(8'h00);
        run_frame();
        chk("t6_id", 32'(f_rx[2]), 32'hAD);
        chk("t6_reg1_cleared", 32'(f_rx[3]), 32'h00);

        repeat (4) @(negedge HCLK);
        chk("final_wr_queue", 32'(exp_wr.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
